// File: rtl/fechadura_pkg.sv
// fechadura_pkg: keypad frame type, digit codes, frame classes and lock FSM states
package fechadura_pkg;
   localparam int N_DIGITOS = 20;
   typedef logic [N_DIGITOS-1:0][3:0] senhaPac_t;
   localparam logic [3:0] DIG_VAZIO     = 4'hF;
   localparam logic [3:0] DIG_LIMPAR    = 4'hB;
   localparam logic [3:0] DIG_EXPIRADO  = 4'hE;
   localparam logic [3:0] DIG_CONFIRMAR = 4'hA;
   typedef enum logic [2:0] {FECHADA, VERIFICAR, ABERTA, NOVA_SENHA, BLOQUEIO} estado_t;
   typedef enum logic [1:0] {ENTRADA, EXPIRADO, LIMPAR, VAZIO} classe_t;
   function automatic logic todos_iguais(input senhaPac_t f, input logic [3:0] d);
      return f == {N_DIGITOS{d}};
   endfunction
   // control frames fill every digit with the same code; anything else is a real entry
   function automatic classe_t classificar(input senhaPac_t f);
      return todos_iguais(f, DIG_EXPIRADO) ? EXPIRADO :
             todos_iguais(f, DIG_LIMPAR)   ? LIMPAR   :
             todos_iguais(f, DIG_VAZIO)    ? VAZIO    : ENTRADA;
   endfunction
endpackage

// File: rtl/temporizador_descendente.sv
// temporizador_descendente: loadable down-counter with zero flag, shared by the open and lockout windows
module temporizador_descendente #(
   parameter int W = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         tick,
   output logic [W-1:0] count,
   output logic         zero
);
   assign zero = count == '0;
   always_ff @(posedge clk)
      if (rst) count <= '0;
      else if (load) count <= value;
      else if (tick && !zero) count <= count - W'(1);
endmodule

// File: rtl/verificador_de_senha.sv
// verificador_de_senha: checks confirmed keypad entries against the stored password, drives lock, lockout and password change
module verificador_de_senha
   import fechadura_pkg::*;
#(
   parameter int        TENTATIVAS_MAX = 3,
   parameter int        T_ABERTA       = 5000,
   parameter int        T_BLOQUEIO     = 30000,
   parameter senhaPac_t SENHA_PADRAO   = {{16{4'hF}}, 16'h1234}
) (
   input  logic       clk,
   input  logic       rst,
   input  senhaPac_t  digitos_value,
   input  logic       digitos_valid,
   input  logic       atualizar_senha,
   output logic       teclado_enable,
   output logic       tranca_aberta,
   output logic       senha_incorreta,
   output logic       bloqueado,
   output logic       senha_gravada,
   output logic [3:0] tentativas
);
   localparam int TW = $clog2(T_ABERTA > T_BLOQUEIO ? T_ABERTA : T_BLOQUEIO);
   estado_t        estado, proximo;
   senhaPac_t      senha_reg, quadro;
   logic           valid_q, novo_quadro, entrada, confere;
   logic           carregar, zero, tick, gravar, incorreta_prox;
   logic [TW-1:0]  valor, contagem;
   logic [3:0]     tent_inc, tent_prox;

   temporizador_descendente #(.W(TW)) u_temporizador (
      .clk(clk), .rst(rst), .load(carregar), .value(valor), .tick(tick), .count(contagem), .zero(zero)
   );

   assign entrada  = novo_quadro && classificar(quadro) == ENTRADA;
   assign confere  = quadro == senha_reg;
   assign tick     = estado inside {ABERTA, NOVA_SENHA, BLOQUEIO};
   assign tent_inc = tentativas >= 4'(TENTATIVAS_MAX) ? tentativas : tentativas + 4'd1;

   // a valid held high for many cycles delivers exactly one frame
   always_ff @(posedge clk)
      if (rst) begin
         valid_q     <= 1'b0;
         novo_quadro <= 1'b0;
         quadro      <= '1;
      end else begin
         valid_q     <= digitos_valid;
         novo_quadro <= digitos_valid && !valid_q;
         if (digitos_valid && !valid_q) quadro <= digitos_value;
      end

   always_comb begin
      proximo        = estado;
      carregar       = 1'b0;
      valor          = '0;
      tent_prox      = tentativas;
      gravar         = 1'b0;
      incorreta_prox = 1'b0;
      case (estado)
         FECHADA:    if (entrada) proximo = VERIFICAR;
         VERIFICAR:
            if (confere) begin
               proximo   = ABERTA;
               tent_prox = '0;
               carregar  = 1'b1;
               valor     = TW'(T_ABERTA - 1);
            end else begin
               incorreta_prox = 1'b1;
               tent_prox      = tent_inc;
               proximo        = tent_inc == 4'(TENTATIVAS_MAX) ? BLOQUEIO : FECHADA;
               carregar       = tent_inc == 4'(TENTATIVAS_MAX);
               valor          = TW'(T_BLOQUEIO - 1);
            end
         ABERTA:     proximo = zero ? FECHADA : atualizar_senha ? NOVA_SENHA : ABERTA;
         // a new entry arriving on the expiry cycle is still stored
         NOVA_SENHA: begin
            gravar  = entrada;
            proximo = (entrada || zero) ? FECHADA : NOVA_SENHA;
         end
         BLOQUEIO:
            if (zero) begin
               proximo   = FECHADA;
               tent_prox = '0;
            end
         default:    proximo = FECHADA;
      endcase
   end

   always_ff @(posedge clk)
      if (rst) begin
         estado          <= FECHADA;
         senha_reg       <= SENHA_PADRAO;
         tentativas      <= '0;
         teclado_enable  <= 1'b1;
         tranca_aberta   <= 1'b0;
         bloqueado       <= 1'b0;
         senha_incorreta <= 1'b0;
         senha_gravada   <= 1'b0;
      end else begin
         estado          <= proximo;
         tentativas      <= tent_prox;
         senha_incorreta <= incorreta_prox;
         senha_gravada   <= gravar;
         tranca_aberta   <= proximo == ABERTA || proximo == NOVA_SENHA;
         bloqueado       <= proximo == BLOQUEIO;
         teclado_enable  <= proximo != BLOQUEIO;
         if (gravar) senha_reg <= quadro;
      end
endmodule

// File: tb/tb_verificador_de_senha.sv
// tb_verificador_de_senha: directed scenarios plus randomized entries against a transaction-level lock model
module tb_verificador_de_senha;
   import fechadura_pkg::*;
   localparam int TMAX = 3, TA = 5000, TB = 30000;
   localparam senhaPac_t PADRAO = {{16{4'hF}}, 16'h1234};
   localparam senhaPac_t ERRADA = {{16{4'hF}}, 16'h1235};
   localparam senhaPac_t NOVA   = {{17{4'hF}}, 12'h987};
   logic       clk = 0, rst = 1, digitos_valid = 0, atualizar_senha = 0;
   senhaPac_t  digitos_value = '1;
   logic       teclado_enable, tranca_aberta, senha_incorreta, bloqueado, senha_gravada;
   logic [3:0] tentativas;
   int         checks = 0, errors = 0, n_inc = 0, n_grav = 0, b, bg;
   senhaPac_t  m_senha = PADRAO;
   int         m_tent = 0;

   verificador_de_senha #(.TENTATIVAS_MAX(TMAX), .T_ABERTA(TA), .T_BLOQUEIO(TB), .SENHA_PADRAO(PADRAO)) dut (
      .clk(clk), .rst(rst), .digitos_value(digitos_value), .digitos_valid(digitos_valid),
      .atualizar_senha(atualizar_senha), .teclado_enable(teclado_enable), .tranca_aberta(tranca_aberta),
      .senha_incorreta(senha_incorreta), .bloqueado(bloqueado), .senha_gravada(senha_gravada),
      .tentativas(tentativas)
   );

   always #5 clk = ~clk;
   always @(posedge clk) begin
      n_inc  <= n_inc + int'(senha_incorreta);
      n_grav <= n_grav + int'(senha_gravada);
   end

   task automatic verificar(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic espera(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic enviar(input senhaPac_t f, input int h);
      digitos_value = f;
      digitos_valid = 1;
      espera(h);
      digitos_valid = 0;
   endtask

   task automatic reiniciar();
      rst = 1;
      espera(1);
      rst = 0;
      m_senha = PADRAO;
      m_tent  = 0;
   endtask

   task automatic saidas(input string tag, input int ab, input int bl, input int tent);
      verificar({tag, ".tranca"}, int'(tranca_aberta), ab);
      verificar({tag, ".bloq"}, int'(bloqueado), bl);
      verificar({tag, ".enable"}, int'(teclado_enable), 1 - bl);
      verificar({tag, ".tent"}, int'(tentativas), tent);
   endtask

   // counts how many sampled cycles the chosen output stays high, bounded
   task automatic medir(input string tag, input bit bloq, input int exp);
      int n = 0;
      while ((bloq ? bloqueado : tranca_aberta) && n < exp + 100) begin
         n++;
         espera(1);
      end
      verificar(tag, n, exp);
   endtask

   function automatic senhaPac_t especial(input int i);
      return i == 0 ? {20{4'hE}} : i == 1 ? {20{4'hB}} : {20{4'hF}};
   endfunction

   function automatic senhaPac_t aleatoria();
      senhaPac_t f = '1;
      int k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) f[i] = 4'($urandom_range(0, 9));
      return f;
   endfunction

   function automatic bit ignorado(input senhaPac_t f);
      return f == {20{4'hE}} || f == {20{4'hB}} || f == {20{4'hF}};
   endfunction

   initial begin
      int op, h;
      bit ign, ok;
      senhaPac_t f;
      espera(2);
      saidas("reset", 0, 0, 0);
      verificar("reset.incorreta", int'(senha_incorreta), 0);
      verificar("reset.gravada", int'(senha_gravada), 0);
      rst = 0;
      espera(1);

      enviar(PADRAO, 1);
      verificar("abre.lat1", int'(tranca_aberta), 0);
      espera(1);
      verificar("abre.lat2", int'(tranca_aberta), 0);
      espera(1);
      saidas("abre", 1, 0, 0);
      medir("abre.duracao", 0, TA);
      saidas("fecha", 0, 0, 0);

      b = n_inc;
      for (int i = 0; i < 2; i++) begin
         enviar(ERRADA, 1);
         espera(3);
         verificar("erro.tent", int'(tentativas), i + 1);
      end
      enviar(ERRADA, 1);
      espera(2);
      saidas("bloqueio", 0, 1, 3);
      medir("bloqueio.duracao", 1, TB);
      verificar("bloqueio.pulsos", n_inc - b, 3);
      saidas("pos_bloqueio", 0, 0, 0);
      enviar(PADRAO, 1);
      espera(2);
      verificar("pos_bloqueio.abre", int'(tranca_aberta), 1);
      reiniciar();

      b = n_inc;
      enviar(ERRADA, 1);
      espera(3);
      for (int i = 0; i < 3; i++) begin
         enviar(especial(i), 1);
         espera(3);
         saidas("especial", 0, 0, 1);
      end
      enviar(ERRADA, 10);
      espera(3);
      verificar("segurado.pulsos", n_inc - b, 2);
      verificar("segurado.tent", int'(tentativas), 2);
      reiniciar();

      enviar(PADRAO, 1);
      espera(2);
      verificar("troca.abre", int'(tranca_aberta), 1);
      espera(5);
      atualizar_senha = 1;
      espera(1);
      atualizar_senha = 0;
      espera(1);
      bg = n_grav;
      enviar(NOVA, 1);
      espera(1);
      verificar("troca.gravada", int'(senha_gravada), 1);
      verificar("troca.fecha", int'(tranca_aberta), 0);
      espera(2);
      verificar("troca.pulsos", n_grav - bg, 1);
      b = n_inc;
      enviar(PADRAO, 1);
      espera(3);
      verificar("troca.antiga_rejeitada", n_inc - b, 1);
      saidas("troca.antiga", 0, 0, 1);
      enviar(NOVA, 1);
      espera(2);
      saidas("troca.nova", 1, 0, 0);
      espera(10);
      rst = 1;
      espera(1);
      saidas("rst_aberta", 0, 0, 0);
      rst = 0;
      espera(1);
      enviar(NOVA, 1);
      espera(2);
      verificar("rst_aberta.nova_rejeitada", int'(senha_incorreta), 1);
      espera(2);
      enviar(PADRAO, 1);
      espera(2);
      verificar("rst_aberta.padrao", int'(tranca_aberta), 1);
      reiniciar();

      for (int i = 0; i < 3; i++) begin
         enviar(ERRADA, 1);
         espera(3);
      end
      verificar("rst_bloq.antes", int'(bloqueado), 1);
      espera(100);
      rst = 1;
      espera(1);
      saidas("rst_bloq", 0, 0, 0);
      rst = 0;
      espera(1);
      enviar(PADRAO, 1);
      espera(2);
      verificar("rst_bloq.abre", int'(tranca_aberta), 1);
      reiniciar();

      // new entry accepted on the very cycle the open window expires
      enviar(PADRAO, 1);
      espera(2);
      atualizar_senha = 1;
      espera(1);
      atualizar_senha = 0;
      espera(TA - 3);
      enviar(NOVA, 1);
      espera(1);
      verificar("limite.gravada", int'(senha_gravada), 1);
      verificar("limite.fecha", int'(tranca_aberta), 0);
      espera(2);
      enviar(NOVA, 1);
      espera(2);
      verificar("limite.nova_abre", int'(tranca_aberta), 1);
      reiniciar();

      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 9);
         h  = $urandom_range(1, 3);
         f  = op < 3 ? especial($urandom_range(0, 2)) : op < 5 ? m_senha : aleatoria();
         ign = ignorado(f);
         ok  = !ign && f == m_senha;
         if (ok) m_tent = 0;
         else if (!ign) m_tent++;
         enviar(f, h);
         espera(3 - h);
         verificar("rnd.incorreta", int'(senha_incorreta), int'(!ign && !ok));
         saidas("rnd", int'(ok), int'(m_tent == TMAX), m_tent);
         if (ok && $urandom_range(0, 1) == 1) begin
            atualizar_senha = 1;
            espera(1);
            atualizar_senha = 0;
            espera(1);
            f = aleatoria();
            enviar(f, 1);
            espera(1);
            verificar("rnd.gravada", int'(senha_gravada), 1);
            verificar("rnd.gravada_fecha", int'(tranca_aberta), 0);
            m_senha = f;
         end else if (ok || m_tent == TMAX) begin
            reiniciar();
         end
         espera(2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
